o_ddr_tx_arbiter: RTL

O_DDR_TX_ARBITER -- requirements
Module: o_ddr_tx_arbiter

---
 rtl/o_ddr_tx_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/o_ddr_tx_arbiter.sv
// o_ddr_tx_arbiter: two-requester round-robin arbiter that serialises words onto
// an O_DDR data pair and drives the O_DDR/O_BUFT enable.
// A grant emits one preamble pair (2'b01). The word then follows two bits per cycle,
// LSB pair first. Up to MAX_BURST words go back-to-back under one grant, and each
// grant ends with TURNAROUND idle-bus cycles.
// Optional build macro: O_DDR_TX_PARITY_EN appends one parity pair {1'b0, ^word}
// after each word.
//
// Handshake: reqN_ready_o is combinational. A word transfers in every cycle where
// reqN_valid_i && reqN_ready_o. ready is raised only in two cases:
//   - in IDLE, for the arbitration winner;
//   - at a word end, for the current owner.
// While valid && !ready the requester holds its data stable. Dropping valid before
// ready cancels the request. Both readys are forced low while reset_n is low.
module o_ddr_tx_arbiter #(
  parameter int WORD_W     = 8,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 2
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              req0_valid_i,
  input  logic [WORD_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [WORD_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  output logic [1:0]        ddr_data_o,
  output logic              ddr_oe_o,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic [2:0]        dbg_state
);

  localparam int IW = (WORD_W > 2) ? $clog2(WORD_W / 2) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_W / 2 - 1);
  localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SHIFT    = 3'd2,
    S_TURN     = 3'd3
`ifdef O_DDR_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [TW-1:0]     turn_q, turn_d;
  logic              owner_q, owner_d;   // 0: requester 0, 1: requester 1
  logic              prio_q, prio_d;     // requester that wins a tie in IDLE

  logic              accept;             // a word transfers this cycle
  logic              sel;                // which requester that word comes from
  logic              word_end;
  logic              own_valid;
  logic [WORD_W-1:0] own_data;

  logic [1:0]        data_d;
  logic              oe_d;
  logic [1:0]        grant_d;
  logic              busy_d;

  assign own_valid    = owner_q ? req1_valid_i : req0_valid_i;
  assign own_data     = owner_q ? req1_data_i  : req0_data_i;
  assign req0_ready_o = reset_n & accept & ~sel;
  assign req1_ready_o = reset_n & accept &  sel;
  assign dbg_state    = state_q;

  // State register plus registered bus outputs; reset aborts any word with no TURN.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      burst_q    <= '0;
      turn_q     <= '0;
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
      ddr_data_o <= 2'b00;
      ddr_oe_o   <= 1'b0;
      grant_o    <= 2'b00;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      burst_q    <= burst_d;
      turn_q     <= turn_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
      ddr_data_o <= data_d;
      ddr_oe_o   <= oe_d;
      grant_o    <= grant_d;
      busy_o     <= busy_d;
    end
  end

  // Next-state logic: arbitration, word loading, burst continuation and turnaround.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    idx_d    = idx_q;
    burst_d  = burst_q;
    turn_d   = turn_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    accept   = 1'b0;
    sel      = owner_q;
    word_end = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          sel     = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
          accept  = 1'b1;
          owner_d = sel;
          word_d  = sel ? req1_data_i : req0_data_i;
          burst_d = BW'(1);
          idx_d   = '0;
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        idx_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (idx_q == LAST_IDX) begin
`ifdef O_DDR_TX_PARITY_EN
          state_d = S_PARITY;
`else
          word_end = 1'b1;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef O_DDR_TX_PARITY_EN
      S_PARITY: begin
        word_end = 1'b1;
      end
`endif
      S_TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = S_IDLE;
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // At a word end the owner may chain another word without a new preamble.
    if (word_end) begin
      if (own_valid && (burst_q < BURST_CAP)) begin
        accept  = 1'b1;
        sel     = owner_q;
        word_d  = own_data;
        burst_d = burst_q + BW'(1);
        idx_d   = '0;
        state_d = S_SHIFT;
      end else begin
        turn_d  = '0;
        prio_d  = ~owner_q;
        state_d = S_TURN;
      end
    end
  end

  // Output decode from the upcoming state, so the registered outputs line up with it.
  always_comb begin
    data_d  = 2'b00;
    oe_d    = 1'b0;
    grant_d = 2'b00;
    busy_d  = (state_d != S_IDLE);
    case (state_d)
      S_PREAMBLE: begin
        oe_d    = 1'b1;
        data_d  = 2'b01;
        grant_d = owner_d ? 2'b10 : 2'b01;
      end
      S_SHIFT: begin
        oe_d    = 1'b1;
        data_d  = word_d[{idx_d, 1'b0} +: 2];
        grant_d = owner_d ? 2'b10 : 2'b01;
      end
`ifdef O_DDR_TX_PARITY_EN
      S_PARITY: begin
        oe_d    = 1'b1;
        data_d  = {1'b0, ^word_d};
        grant_d = owner_d ? 2'b10 : 2'b01;
      end
`endif
      default: begin
        data_d  = 2'b00;
      end
    endcase
  end

endmodule
